// File: rtl/host_descriptor_arbiter_pkg.sv
// Shared widths, FSM encoding and FIFO entry layout for the host descriptor arbiter.
package host_descriptor_arbiter_pkg;

    localparam int DESC_W  = 57;
    localparam int BUFID_W = 9;
    localparam int ENTRY_W = DESC_W + 1;

    typedef enum logic {
        ARB_S = 1'b0,
        ACK_S = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              flag;
        logic [DESC_W-1:0] desc;
    } fifo_entry_t;

    function automatic logic [BUFID_W-1:0] desc_bufid(input logic [DESC_W-1:0] desc);
        return desc[BUFID_W-1:0];
    endfunction

endpackage

// File: rtl/host_descriptor_arbiter_fifo.sv
// descriptor_fifo: synchronous first-word-fall-through FIFO holding {flag, descriptor} entries.
module descriptor_fifo
    import host_descriptor_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [AW:0]      used_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    head_ptr;
    logic [AW:0]      used_q, used_d;
    logic             wr_en, rd_en;

    assign empty_o = (used_q == '0);
    assign full_o  = (used_q == (AW+1)'(DEPTH));
    assign wr_en   = wr_i && !full_o;
    assign rd_en   = rd_i && !empty_o;
    assign used_o  = used_q;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        used_d   = used_q;
        case ({wr_en, rd_en})
            2'b10:   used_d = used_q + 1'b1;
            2'b01:   used_d = used_q - 1'b1;
            default: used_d = used_q;
        endcase
    end

    // When empty, keep showing the slot just popped so the head value holds.
    assign head_ptr = empty_o ? rd_ptr_q - 1'b1 : rd_ptr_q;
    assign rdata_o  = mem_q[head_ptr];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
        end
    end

endmodule

// File: rtl/host_descriptor_arbiter.sv
// Round-robin arbiter collecting per-port descriptor writes into a FWFT FIFO for the host path.
// Optional statistics ports are enabled by defining HOST_DESCRIPTOR_ARB_STAT_EN.
//
// state | meaning
// ARB_S | look for a requester; grant, push and ack it when the FIFO has room
// ACK_S | ack pulse is out, granted port still holds wr, so no grant this cycle
module host_descriptor_arbiter
    import host_descriptor_arbiter_pkg::*;
#(
    parameter int PORT_NUM   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic [PORT_NUM-1:0]        iv_descriptor_wr,
    input  logic [DESC_W*PORT_NUM-1:0] iv_descriptor,
    input  logic [PORT_NUM-1:0]        iv_inverse_map_lookup_flag,
    output logic [PORT_NUM-1:0]        ov_descriptor_ack,
    output logic                       o_descriptor_wr,
    output logic [DESC_W-1:0]          ov_descriptor,
    output logic                       o_inverse_map_lookup_flag,
    input  logic                       i_descriptor_ready,
    output logic [FIFO_AW:0]           ov_fifo_used
`ifdef HOST_DESCRIPTOR_ARB_STAT_EN
    ,
    output logic [15:0]                ov_forward_cnt,
    output logic [FIFO_AW:0]           ov_fifo_peak_used
`endif
);

    localparam int PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    typedef logic [PORT_NUM-1:0][DESC_W-1:0] desc_vec_t;

    desc_vec_t           desc_arr;
    arb_state_e          state_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PORT_NUM-1:0] ack_q;

    logic                grant_vld;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    rr_ptr_d;
    logic [PTR_W:0]      cand_sum;
    logic [PTR_W-1:0]    cand_idx;
    logic                push;
    logic                pop;
    fifo_entry_t         push_entry;
    fifo_entry_t         head_entry;
    logic                fifo_empty;
    logic                fifo_full;
    logic [FIFO_AW:0]    fifo_used;

    assign desc_arr = iv_descriptor;

    // Scan from the highest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            cand_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand_sum >= (PTR_W+1)'(PORT_NUM)) begin
                cand_sum = cand_sum - (PTR_W+1)'(PORT_NUM);
            end
            cand_idx = cand_sum[PTR_W-1:0];
            if (iv_descriptor_wr[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign rr_ptr_d = (grant_idx == PTR_W'(PORT_NUM - 1)) ? '0 : grant_idx + 1'b1;
    assign push     = (state_q == ARB_S) && grant_vld && !fifo_full;
    assign pop      = o_descriptor_wr && i_descriptor_ready;

    always_comb begin
        push_entry      = '0;
        push_entry.flag = iv_inverse_map_lookup_flag[grant_idx];
        push_entry.desc = desc_arr[grant_idx];
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_S;
            rr_ptr_q <= '0;
            ack_q    <= '0;
        end else begin
            case (state_q)
                ARB_S: begin
                    if (push) begin
                        ack_q    <= PORT_NUM'(1) << grant_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ACK_S;
                    end else begin
                        ack_q <= '0;
                    end
                end
                ACK_S: begin
                    ack_q   <= '0;
                    state_q <= ARB_S;
                end
                default: begin
                    ack_q   <= '0;
                    state_q <= ARB_S;
                end
            endcase
        end
    end

    descriptor_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .wr_i    (push),
        .wdata_i (push_entry),
        .rd_i    (pop),
        .rdata_o (head_entry),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .used_o  (fifo_used)
    );

    assign ov_descriptor_ack         = ack_q;
    assign o_descriptor_wr           = !fifo_empty;
    assign ov_descriptor             = head_entry.desc;
    assign o_inverse_map_lookup_flag = head_entry.flag;
    assign ov_fifo_used              = fifo_used;

`ifdef HOST_DESCRIPTOR_ARB_STAT_EN
    logic [15:0]      fwd_cnt_q;
    logic [FIFO_AW:0] peak_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            fwd_cnt_q <= '0;
            peak_q    <= '0;
        end else begin
            if (pop) begin
                fwd_cnt_q <= fwd_cnt_q + 16'd1;
            end
            if (fifo_used > peak_q) begin
                peak_q <= fifo_used;
            end
        end
    end

    assign ov_forward_cnt    = fwd_cnt_q;
    assign ov_fifo_peak_used = peak_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_host_descriptor_arbiter.sv
// Bench for host_descriptor_arbiter: grant table, scoreboarded FIFO traffic and multi-cycle corner cases.
module tb_host_descriptor_arbiter;

    localparam int PN  = 4;
    localparam int FD  = 4;
    localparam int FAW = 2;

    typedef logic [57:0] ent_t;
    typedef struct {
        logic [PN-1:0] req;
        logic [PN-1:0] exp_ack;
    } vec_t;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic [PN-1:0]     wr_drv;
    logic [PN-1:0]     flag_drv;
    logic [56:0]       desc_drv [PN];
    logic [57*PN-1:0]  desc_bus;
    logic              ready;

    logic [PN-1:0]     ack;
    logic              owr;
    logic [56:0]       odesc;
    logic              oflag;
    logic [FAW:0]      used;
`ifdef HOST_DESCRIPTOR_ARB_STAT_EN
    logic [15:0]       fwd_cnt;
    logic [FAW:0]      peak;
`endif

    assign desc_bus = {desc_drv[3], desc_drv[2], desc_drv[1], desc_drv[0]};

    host_descriptor_arbiter #(
        .PORT_NUM   (PN),
        .FIFO_DEPTH (FD),
        .FIFO_AW    (FAW)
    ) dut (
        .clk_sys                    (clk_sys),
        .reset                      (reset),
        .iv_descriptor_wr           (wr_drv),
        .iv_descriptor              (desc_bus),
        .iv_inverse_map_lookup_flag (flag_drv),
        .ov_descriptor_ack          (ack),
        .o_descriptor_wr            (owr),
        .ov_descriptor              (odesc),
        .o_inverse_map_lookup_flag  (oflag),
        .i_descriptor_ready         (ready),
        .ov_fifo_used               (used)
`ifdef HOST_DESCRIPTOR_ARB_STAT_EN
        ,
        .ov_forward_cnt             (fwd_cnt),
        .ov_fifo_peak_used          (peak)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int            vecs   = 0;
    int            miscmp = 0;
    int            cyc    = 0;
    bit            auto_mode;
    int            rem [PN];
    logic [8:0]    bufid_nxt [PN];
    logic [PN-1:0] drop_pend;
    ent_t          sb_q [$];
    int            grant_log [$];
    int            grant_cyc [$];
    logic [8:0]    pop_bufid [$];
    vec_t          tbl [10];
    int            rr_exp [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [56:0] mk_desc(input logic [8:0] b);
        return {$urandom(), 16'($urandom()), b};
    endfunction

    // Upstream sender: holds wr, and after an ack reloads the next descriptor or drops wr.
    task automatic raise(input int k, input int extra, input logic [8:0] b0);
        bufid_nxt[k] = b0 + 9'd1;
        rem[k]       = extra;
        desc_drv[k]  = mk_desc(b0);
        flag_drv[k]  = 1'($urandom());
        wr_drv[k]    = 1'b1;
    endtask

    task automatic step();
        ent_t e;
        if (owr && ready) begin
            if (sb_q.size() == 0) begin
                vecs++;
                miscmp++;
                $display("FAIL pop_unexpected: got valid head %0h expected empty", odesc);
            end else begin
                e = sb_q.pop_front();
                chk("pop_head", {6'd0, oflag, odesc}, {6'd0, e});
                pop_bufid.push_back(odesc[8:0]);
            end
        end
        @(posedge clk_sys);
        #1;
        cyc++;
        chk("ack_onehot", 64'($countones(ack) <= 1), 64'd1);
        for (int k = 0; k < PN; k++) begin
            if (ack[k]) begin
                sb_q.push_back({flag_drv[k], desc_drv[k]});
                grant_log.push_back(k);
                grant_cyc.push_back(cyc);
            end
        end
        if (auto_mode) begin
            for (int k = 0; k < PN; k++) begin
                if (drop_pend[k]) begin
                    if (rem[k] > 0) begin
                        rem[k]--;
                        desc_drv[k]  = mk_desc(bufid_nxt[k]);
                        bufid_nxt[k] = bufid_nxt[k] + 9'd1;
                        flag_drv[k]  = 1'($urandom());
                    end else begin
                        wr_drv[k] = 1'b0;
                    end
                end
            end
            drop_pend = ack;
        end else begin
            drop_pend = '0;
        end
        chk("used_track", 64'(used), 64'(sb_q.size()));
        chk("valid_track", 64'(owr), 64'(sb_q.size() != 0));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        wr_drv    = '0;
        ready     = 1'b0;
        auto_mode = 1'b0;
        drop_pend = '0;
        sb_q.delete();
        grant_log.delete();
        grant_cyc.delete();
        pop_bufid.delete();
        for (int k = 0; k < PN; k++) rem[k] = 0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n     = 0;
        ready = 1'b1;
        while ((wr_drv != '0 || sb_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", 64'(wr_drv == '0 && sb_q.size() == 0), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0100, 4'b0100};
        tbl[1] = '{4'b0011, 4'b0001};
        tbl[2] = '{4'b1001, 4'b1000};
        tbl[3] = '{4'b1111, 4'b0001};
        tbl[4] = '{4'b0001, 4'b0001};
        tbl[5] = '{4'b0000, 4'b0000};
        tbl[6] = '{4'b1100, 4'b0100};
        tbl[7] = '{4'b0110, 4'b0010};
        tbl[8] = '{4'b1010, 4'b1000};
        tbl[9] = '{4'b0010, 4'b0010};
        rr_exp = '{0, 1, 2, 3, 0};

        reset    = 1'b1;
        wr_drv   = '0;
        flag_drv = '0;
        ready    = 1'b0;
        for (int k = 0; k < PN; k++) desc_drv[k] = '0;
        drop_pend = '0;
        auto_mode = 1'b0;
        #3;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_valid", 64'(owr), 64'd0);
        chk("rst_desc", 64'(odesc), 64'd0);
        chk("rst_flag", 64'(oflag), 64'd0);
        chk("rst_used", 64'(used), 64'd0);
`ifdef HOST_DESCRIPTOR_ARB_STAT_EN
        chk("rst_fwd_cnt", 64'(fwd_cnt), 64'd0);
        chk("rst_peak", 64'(peak), 64'd0);
`endif
        @(negedge clk_sys);
        reset = 1'b0;

        // Single request from port 2
        wr_drv[2]   = 1'b1;
        desc_drv[2] = 57'h1_2345_6789_A0FF;
        flag_drv[2] = 1'b1;
        step();
        chk("single_ack", 64'(ack), 64'b0100);
        chk("single_valid", 64'(owr), 64'd1);
        chk("single_desc", 64'(odesc), 64'h1_2345_6789_A0FF);
        chk("single_flag", 64'(oflag), 64'd1);
        step();
        chk("single_ack_pulse", 64'(ack), 64'd0);
        wr_drv[2] = 1'b0;
        drain(10);

        // Grant table from a fresh round-robin pointer
        do_reset();
        ready = 1'b1;
        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < PN; k++) begin
                desc_drv[k] = mk_desc(9'(v * 4 + k));
                flag_drv[k] = 1'($urandom());
            end
            wr_drv = tbl[v].req;
            step();
            chk($sformatf("tbl_ack[%0d]", v), 64'(ack), 64'(tbl[v].exp_ack));
            step();
            chk($sformatf("tbl_ack_clr[%0d]", v), 64'(ack), 64'd0);
            wr_drv = '0;
            step();
        end
        drain(10);

        // Round robin with all ports requesting continuously
        do_reset();
        auto_mode = 1'b1;
        ready     = 1'b1;
        for (int k = 0; k < PN; k++) raise(k, 1, 9'(9'h100 + k * 16));
        for (int n = 0; n < 30 && grant_log.size() < 5; n++) step();
        if (grant_log.size() < 5) begin
            vecs++;
            miscmp++;
            $display("FAIL rr_count: got %0d grants expected at least 5", grant_log.size());
        end else begin
            for (int i = 0; i < 5; i++) chk($sformatf("rr_order[%0d]", i), 64'(grant_log[i]), 64'(rr_exp[i]));
            for (int i = 0; i < 4; i++) chk($sformatf("rr_spacing[%0d]", i), 64'(grant_cyc[i+1] - grant_cyc[i]), 64'd2);
        end
        drain(60);

        // FIFO full with six requests outstanding
        do_reset();
        auto_mode = 1'b1;
        raise(0, 1, 9'h020);
        raise(1, 1, 9'h030);
        raise(2, 0, 9'h040);
        raise(3, 0, 9'h050);
        repeat (12) step();
        chk("full_ack_count", 64'(grant_log.size()), 64'd4);
        chk("full_used", 64'(used), 64'd4);
        chk("full_valid", 64'(owr), 64'd1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("full_pop_noack", 64'(ack), 64'd0);
        chk("full_pop_used", 64'(used), 64'd3);
        step();
        chk("full_regrant_ack", 64'(ack), 64'b0001);
        chk("full_regrant_used", 64'(used), 64'd4);
        drain(60);

        // Simultaneous push and pop with a port-0 stream
        do_reset();
        auto_mode = 1'b1;
        raise(0, 2, 9'h010);
        step();
        step();
        ready = 1'b1;
        step();
        chk("simul_ack", 64'(ack), 64'b0001);
        chk("simul_used", 64'(used), 64'd1);
        for (int n = 0; n < 8; n++) begin
            step();
            chk("stream_used_le1", 64'(used <= 1), 64'd1);
        end
        chk("stream_pops", 64'(pop_bufid.size()), 64'd3);
        if (pop_bufid.size() == 3) begin
            chk("stream_bufid0", 64'(pop_bufid[0]), 64'h010);
            chk("stream_bufid1", 64'(pop_bufid[1]), 64'h011);
            chk("stream_bufid2", 64'(pop_bufid[2]), 64'h012);
        end

        // Reset while three entries are buffered and an ack is out
        do_reset();
        auto_mode = 1'b1;
        for (int k = 0; k < PN; k++) raise(k, 0, 9'(9'h060 + k));
        for (int n = 0; n < 12 && grant_log.size() < 3; n++) step();
        chk("midrst_pre_used", 64'(used), 64'd3);
        chk("midrst_pre_ack", 64'(ack), 64'b0100);
        reset = 1'b1;
        #2;
        chk("midrst_ack", 64'(ack), 64'd0);
        chk("midrst_valid", 64'(owr), 64'd0);
        chk("midrst_desc", 64'(odesc), 64'd0);
        chk("midrst_flag", 64'(oflag), 64'd0);
        chk("midrst_used", 64'(used), 64'd0);
        sb_q.delete();
        wr_drv    = '0;
        drop_pend = '0;
        @(negedge clk_sys);
        reset = 1'b0;
        for (int k = 0; k < PN; k++) raise(k, 0, 9'(9'h070 + k));
        step();
        chk("midrst_first_grant", 64'(ack), 64'b0001);
        drain(60);

`ifdef HOST_DESCRIPTOR_ARB_STAT_EN
        // Statistics: five pops with a peak occupancy of three
        do_reset();
        auto_mode = 1'b1;
        raise(0, 1, 9'h080);
        raise(1, 1, 9'h090);
        raise(2, 0, 9'h0A0);
        for (int n = 0; n < 12 && used != 3; n++) step();
        drain(60);
        chk("stat_fwd_cnt", 64'(fwd_cnt), 64'd5);
        chk("stat_peak", 64'(peak), 64'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule

// File: doc/host_descriptor_arbiter.md
Name: host_descriptor_arbiter

Overview:
- Downstream neighbour of the per-port frame-parser descriptor senders.
- Collects host-bound descriptor writes (57-bit descriptor plus inverse-map lookup flag) from PORT_NUM input ports using the wr/ack handshake.
- Arbitrates round-robin into a small first-word-fall-through (FWFT) FIFO.
- Presents a single valid/ready descriptor stream to the host transmit path.

Parameters:
- PORT_NUM, 4, number of upstream descriptor senders (2..8).
- FIFO_DEPTH, 4, descriptor FIFO entries (power of two, 2..16).
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- iv_descriptor_wr  in  PORT_NUM  per-port write request; held high until acked.
- iv_descriptor  in  57*PORT_NUM  per-port descriptor; port k occupies bits [57k+56:57k]; bits [8:0] are pkt_bufid.
- iv_inverse_map_lookup_flag  in  PORT_NUM  per-port flag travelling with the descriptor.
- ov_descriptor_ack  out  PORT_NUM  one-cycle ack pulse to the granted port.
- o_descriptor_wr  out  1  output valid (FIFO not empty).
- ov_descriptor  out  57  FIFO head descriptor.
- o_inverse_map_lookup_flag  out  1  FIFO head flag.
- i_descriptor_ready  in  1  downstream accept; pop occurs when o_descriptor_wr && i_descriptor_ready.
- ov_fifo_used  out  FIFO_AW+1  current occupancy.

Behaviour:
- Reset: all outputs 0, FIFO empty, round-robin pointer = port 0, FSM in ARB_S.
- Reset mid-operation discards buffered descriptors. Upstream senders share this reset domain.
- FSM has two states:
  - ARB_S: when ov_fifo_used < FIFO_DEPTH and any iv_descriptor_wr bit is set, grant the first requesting port at or after rr_ptr (wrapping).
    - Push {flag, descriptor} of that port into the FIFO.
    - Register ov_descriptor_ack[k] = 1.
    - Set rr_ptr = k+1 (mod PORT_NUM).
    - Go to ACK_S.
    - Otherwise stay in ARB_S with acks 0.
  - ACK_S: ack is high this cycle and the granted port's wr is still high, so no grant is made. Ack returns to 0 next cycle; go to ARB_S.
- Throughput: at most one push per 2 cycles.
- Latency: request sampled at cycle t; ack and FIFO write visible at t+1; o_descriptor_wr high at t+1 if the FIFO was empty (FWFT).
- Full: no grant while used == FIFO_DEPTH. A pop in the same cycle does not enable a push; the grant waits one cycle.
- Simultaneous push and pop: used is unchanged. Head/tail pointers wrap modulo FIFO_DEPTH.
- Empty: o_descriptor_wr = 0. ov_descriptor and flag hold the last head value, and downstream must not use them.
- Pop while empty never occurs, because pop is gated by o_descriptor_wr.
- Descriptor content is never modified.

Optional Feature:
- Macro: HOST_DESCRIPTOR_ARB_STAT_EN.
- When defined, two extra output ports are added:
  - ov_forward_cnt (16 bits): increments on every pop, wraps at 16'hFFFF->0.
  - ov_fifo_peak_used (FIFO_AW+1 bits): maximum used since reset, monotonic.
  - Both reset to 0.
- When undefined, neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - DESC_W = 57, BUFID_W = 9.
  - ARB_S/ACK_S state encodings (1 bit).
  - FIFO entry width = DESC_W+1.
- Sub-module descriptor_fifo: synchronous FWFT FIFO.
  - Interface: wr, wdata, rd, rdata, empty, full, used.
  - Parameterised by depth and width.
- Arbiter FSM and round-robin logic stay in the top module.

Test Plan:
- Single request: port 2 raises wr with descriptor 57'h1_2345_6789_A0FF and flag 1, holding until ack.
  - Expect ov_descriptor_ack = 4'b0100 for exactly 1 cycle, next cycle.
  - Expect o_descriptor_wr = 1 with the same descriptor and flag 1 in that same cycle.
- Round-robin: all 4 ports request continuously (each re-raises after ack).
  - Expect grant order 0,1,2,3,0 with acks spaced exactly 2 cycles apart.
- Full: i_descriptor_ready = 0 while 6 requests arrive.
  - Expect exactly 4 acks, used = 4, and the remaining ports held unacked.
  - Raise ready for 1 cycle: pop 1, then a new ack 2 cycles later.
- Simultaneous push and pop: ready = 1 with a steady stream from port 0.
  - Expect used to stay at 0..1, and bufids in order 9'h010, 9'h011, 9'h012.
- Reset mid-operation: assert reset while used = 3 and ack is high.
  - Expect all outputs 0 immediately (async), used = 0, and the first grant after release to go to port 0.
- With HOST_DESCRIPTOR_ARB_STAT_EN: after 5 pops with a peak of 3 entries, expect ov_forward_cnt = 5 and ov_fifo_peak_used = 3.
